// File: rtl/uart_pkg.sv
// Shared types and constants for the parametrised UART receiver with FIFO.
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_START     = 3'd1,
    ST_DATA      = 3'd2,
    ST_PARITY    = 3'd3,
    ST_STOP      = 3'd4,
    ST_WAIT_IDLE = 3'd5
  } rx_state_e;

  localparam int PAR_NONE = 0;
  localparam int PAR_ODD  = 1;
  localparam int PAR_EVEN = 2;

  localparam logic [15:0] OUT_EMPTY = 16'h8000;

  function automatic int bit_period(input int clk_hz, input int baud);
    return clk_hz / baud;
  endfunction

endpackage

// File: rtl/uart_rx_fifo_if.sv
// Host-side register interface of the UART receiver: FIFO head, pop, sticky errors.
interface uart_rx_fifo_if;
  logic        rd_en;
  logic        err_clr;
  logic [15:0] out;
  logic        rx_ready;
  logic        frame_err;
  logic        parity_err;
  logic        overrun;

  modport master (
    output rd_en, err_clr,
    input  out, rx_ready, frame_err, parity_err, overrun
  );

  modport slave (
    input  rd_en, err_clr,
    output out, rx_ready, frame_err, parity_err, overrun
  );
endinterface

// File: rtl/uart_rx_fifo_sync_fifo.sv
// Synchronous FIFO with wrap-bit pointers; a pop on an empty FIFO is ignored.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic             clk,
  input  logic             clear,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] head,
  output logic             full,
  output logic             empty,
  output logic             drop
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic [WIDTH-1:0] mem [DEPTH];
  logic             pop_ok;
  logic             push_ok;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign pop_ok  = pop && !empty;
  // A pop on the same cycle frees the slot, so a full FIFO still accepts the push.
  assign push_ok = push && (!full || pop_ok);
  assign drop    = push && !push_ok;
  assign head    = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (pop_ok)  rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr[AW-1:0]] <= din;
  end

endmodule

// File: rtl/uart_rx_fifo.sv
// UART receiver: 2-flop synchroniser, majority-voted bit FSM, sticky errors, byte FIFO.
module uart_rx_fifo
  import uart_pkg::*;
#(
  parameter int CLK_FREQ   = 100000000,
  parameter int BAUD_RATE  = 115200,
  parameter int DATA_BITS  = 8,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1,
  parameter int FIFO_DEPTH = 16
) (
  input  logic          CLK_100MHz,
  input  logic          clear,
  input  logic          RX,
  uart_rx_fifo_if.slave bus
);

  localparam int BIT_PERIOD = bit_period(CLK_FREQ, BAUD_RATE);
  localparam int MID        = (BIT_PERIOD - 1) / 2;
  localparam int CNT_W      = $clog2(BIT_PERIOD);

  rx_state_e            state;
  rx_state_e            state_nxt;
  logic                 rx_p0;
  logic                 rx_p1;
  logic                 rxs;
  logic [CNT_W-1:0]     cnt;
  logic [2:0]           bit_idx;
  logic                 stop_idx;
  logic [1:0]           samp;
  logic [DATA_BITS-1:0] shift;
  logic                 bad;
  logic                 frame_err_q;
  logic                 parity_err_q;
  logic                 overrun_q;

  logic                 decide;
  logic                 maj;
  logic                 par_bad;
  logic                 push;
  logic                 set_fe;
  logic                 set_pe;
  logic                 fifo_drop;
  logic                 fifo_full;
  logic                 fifo_empty;
  logic [7:0]           fifo_head;

  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

  function automatic logic parity_mismatch(input logic [DATA_BITS-1:0] d, input logic p);
    logic x;
    x = (^d) ^ p;
    return (PARITY == PAR_ODD) ? ~x : x;
  endfunction

  assign rxs     = rx_p1;
  assign decide  = (cnt == CNT_W'(MID + 1));
  assign maj     = maj3(samp[0], samp[1], rxs);
  assign par_bad = parity_mismatch(shift, maj);

  // ---- stage p0/p1: line synchroniser, bit FSM and control registers ----
  always_ff @(posedge CLK_100MHz) begin
    if (clear) begin
      rx_p0        <= 1'b1;
      rx_p1        <= 1'b1;
      state        <= ST_IDLE;
      cnt          <= '0;
      bit_idx      <= '0;
      stop_idx     <= 1'b0;
      bad          <= 1'b0;
      frame_err_q  <= 1'b0;
      parity_err_q <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      rx_p0 <= RX;
      rx_p1 <= rx_p0;
      state <= state_nxt;
      // The counter free-runs through every cell so cell boundaries stay anchored to the start edge.
      if (state == ST_IDLE)
        cnt <= '0;
      else if (cnt == CNT_W'(BIT_PERIOD - 1))
        cnt <= '0;
      else
        cnt <= cnt + CNT_W'(1);

      if (state == ST_IDLE)
        bit_idx <= '0;
      else if (state == ST_DATA && decide)
        bit_idx <= bit_idx + 3'd1;

      if (state == ST_IDLE)
        stop_idx <= 1'b0;
      else if (state == ST_STOP && decide)
        stop_idx <= ~stop_idx;

      if (state == ST_IDLE)
        bad <= 1'b0;
      else if (state == ST_PARITY && decide)
        bad <= par_bad;

      // New error events win over a simultaneous err_clr.
      frame_err_q  <= set_fe | (frame_err_q  & ~bus.err_clr);
      parity_err_q <= set_pe | (parity_err_q & ~bus.err_clr);
      overrun_q    <= (push & fifo_drop) | (overrun_q & ~bus.err_clr);
    end
  end

  always_ff @(posedge CLK_100MHz) begin
    if (cnt == CNT_W'(MID - 1)) samp[0] <= rxs;
    if (cnt == CNT_W'(MID))     samp[1] <= rxs;
    if (state == ST_DATA && decide) shift <= {maj, shift[DATA_BITS-1:1]};
  end

  always_comb begin
    state_nxt = state;
    push      = 1'b0;
    set_fe    = 1'b0;
    set_pe    = 1'b0;
    case (state)
      ST_IDLE: begin
        if (!rxs) state_nxt = ST_START;
      end
      ST_START: begin
        if (decide) state_nxt = maj ? ST_IDLE : ST_DATA;
      end
      ST_DATA: begin
        if (decide && bit_idx == 3'(DATA_BITS - 1))
          state_nxt = (PARITY != PAR_NONE) ? ST_PARITY : ST_STOP;
      end
      ST_PARITY: begin
        if (decide) state_nxt = ST_STOP;
      end
      ST_STOP: begin
        if (decide) begin
          if (!maj) begin
            set_fe    = 1'b1;
            state_nxt = ST_WAIT_IDLE;
          end else if (stop_idx == 1'(STOP_BITS - 1)) begin
            state_nxt = ST_IDLE;
            if (bad) set_pe = 1'b1;
            else     push   = 1'b1;
          end
        end
      end
      ST_WAIT_IDLE: begin
        if (rxs) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // ---- stage p2: received-byte FIFO and host outputs ----
  sync_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (CLK_100MHz),
    .clear (clear),
    .push  (push),
    .pop   (bus.rd_en),
    .din   (8'(shift)),
    .head  (fifo_head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .drop  (fifo_drop)
  );

  assign bus.out        = fifo_empty ? OUT_EMPTY : {8'h00, fifo_head};
  assign bus.rx_ready   = ~fifo_empty;
  assign bus.frame_err  = frame_err_q;
  assign bus.parity_err = parity_err_q;
  assign bus.overrun    = overrun_q;

endmodule

// File: doc/uart_rx_fifo.md
Name: uart_rx_fifo

Overview:
Parametrised UART receiver, the successor to the fixed 8N1 receiver.
- Configurable frame format: 5-8 data bits, none/odd/even parity, 1 or 2 stop bits.
- Triple-sample majority vote at mid-bit, plus frame, parity and overrun error detection.
- Received bytes buffer in a small FIFO with an explicit pop handshake.
- Sits between the board RX pin and the Hack memory-mapped input register; keeps the `out[15]` = "no data" convention.

Parameters:
- CLK_FREQ, 100000000: system clock frequency in Hz.
- BAUD_RATE, 115200: line rate. BIT_PERIOD = CLK_FREQ/BAUD_RATE (integer divide); must be >= 8.
- DATA_BITS, 8: data bits per frame, legal 5..8.
- PARITY, 0: 0 = none, 1 = odd, 2 = even.
- STOP_BITS, 1: legal 1 or 2.
- FIFO_DEPTH, 16: entries; power of two, >= 2.

Ports:
- CLK_100MHz, in, 1: system clock; all logic on rising edge.
- clear, in, 1: synchronous active-high reset.
- RX, in, 1: asynchronous UART line, idle high.
- rd_en, in, 1: pop FIFO head this cycle.
- err_clr, in, 1: clear sticky error flags.
- out, out, 16: FIFO head data. Bit 15 = 1 when empty.
- rx_ready, out, 1: FIFO non-empty.
- frame_err, out, 1: sticky; a stop bit sampled low.
- parity_err, out, 1: sticky; parity mismatch.
- overrun, out, 1: sticky; good frame arrived with FIFO full.

Behaviour:
- Reset (`clear`), takes effect on the next edge: state = IDLE; counters = 0; FIFO empty; synchroniser flops = 1; out = 16'h8000; rx_ready, frame_err, parity_err, overrun = 0.
- RX passes through a 2-flop synchroniser; all FSM logic uses the synchronised line (rxs).
- Sampling: each bit cell's value is the majority of rxs at counts MID-1, MID, MID+1, where MID = (BIT_PERIOD-1)/2. Decision is taken at count MID+1.
- States IDLE, START, DATA, PARITY, STOP, WAIT_IDLE:
  - IDLE: rxs == 0 -> START, count = 0.
  - START: majority 1 -> IDLE (glitch rejected). Majority 0 -> DATA.
  - DATA: DATA_BITS cells, each BIT_PERIOD apart, LSB first into a shift register. Then -> PARITY if PARITY != 0, else -> STOP.
  - PARITY: compare against the XOR of data bits (odd: XOR of data and parity bit == 1; even: == 0). Mismatch sets a per-frame bad flag.
  - STOP: STOP_BITS cells.
    - A cell sampled 0: set frame_err, discard frame, -> WAIT_IDLE.
    - All cells 1 with bad flag set: set parity_err, discard frame, -> IDLE.
    - All cells 1, frame good: push zero-extended byte, -> IDLE.
  - WAIT_IDLE: stay until rxs == 1 (covers break), then -> IDLE.
- Counter: 0..BIT_PERIOD-1, wraps to 0 at every cell boundary. The first data cell is timed from the start cell's count-0 edge + BIT_PERIOD.
- Push happens on the cycle of the final stop-bit decision. rx_ready and out reflect the new head on the next cycle.
- out: head byte zero-extended to 16 bits (bit 15 = 0) when non-empty; 16'h8000 when empty. Driven from registers only.
- rd_en when empty: ignored. rd_en when non-empty: head advances on the next edge.
- Full FIFO with push and no pop: byte dropped, overrun set, contents unchanged.
- Full FIFO with push and pop on the same cycle: both succeed, no overrun.
- Empty FIFO with push and pop on the same cycle: pop ignored, push succeeds.
- Error flags are sticky until err_clr or clear. If err_clr coincides with a new error event, the set wins.
- Pointers carry one extra wrap bit; full = MSBs differ and LSBs equal.
- clear mid-frame aborts the frame; nothing is pushed; the FSM restarts from IDLE.

Decomposition:
- Package uart_pkg:
  - FSM state encoding (3 bits).
  - Parity mode constants PAR_NONE/PAR_ODD/PAR_EVEN.
  - Function bit_period(clk, baud).
  - Constant OUT_EMPTY = 16'h8000.
- One sub-module, sync_fifo (WIDTH, DEPTH): push/pop/full/empty/head, synchronous clear. This module owns the synchroniser, FSM and error logic.

Test Plan:
All cases use CLK_FREQ=1600, BAUD_RATE=100 (BIT_PERIOD=16), 8N1 unless stated.
- Send 0xA5 -> rx_ready = 1 within 16*10+4 cycles, out = 16'h00A5. Pulse rd_en -> out = 16'h8000, rx_ready = 0 next cycle.
- PARITY=2: send 0x03 with parity bit 1 -> parity_err = 1, FIFO empty. Then send 0x03 with parity bit 0 -> out = 16'h0003, parity_err still 1. err_clr -> flag = 0.
- Stop bit held 0, then line low for 40 cycles -> frame_err = 1, nothing pushed. Next good frame 0x55 is received correctly.
- 5-cycle low glitch on idle line -> no state change beyond START, no push, no flags.
- FIFO_DEPTH=4: send 5 bytes 0x01..0x05 without reads -> overrun = 1. Reads return 0x01..0x04, then out = 16'h8000.
- Assert clear midway through the data bits of 0xFF -> out = 16'h8000, flags = 0, no push. Next frame 0x3C is received intact.
